// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM states, baud divider.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    // Clock cycles per bit period; the transmitter uses the same rounding.
    function automatic int calcBaudDiv(input int clkFreq, input int baudRate);
        return clkFreq / baudRate;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Single-frame UART receiver: synchroniser, baud counter and byte FSM.
// The byte_done, par_err and frm_err outputs are valid only in the stop-sample cycle.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BR       = 115200,
    parameter int CHECK    = PAR_ODD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_done,
    output logic       par_err,
    output logic       frm_err,
    output logic       rx_idle
);

    localparam int BAUD_DIV = calcBaudDiv(CLK_FREQ, BR);
    localparam int HALF     = BAUD_DIV / 2;
    localparam int CW       = $clog2(BAUD_DIV);

    logic          rx_meta_q, rx_s_q, rx_d_q;
    logic          fall_edge;
    logic          tick, half_tick;
    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_err_q, par_err_d;

    // Two-flop synchroniser plus one delay flop, all idling high so reset is not seen as a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_d_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_d_q    <= rx_s_q;
        end
    end

    assign fall_edge = rx_d_q & ~rx_s_q;
    assign tick      = (cnt_q == CW'(BAUD_DIV - 1));
    assign half_tick = (cnt_q == CW'(HALF));

    // State, baud counter, bit counter, shift register and latched parity error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_err_q <= par_err_d;
        end
    end

    // After the start sample the counter restarts at 0, so every later sample lands one full bit on, at mid-bit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = tick ? '0 : cnt_q + 1'b1;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_err_d = par_err_q;
        byte_done = 1'b0;
        frm_err   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (fall_edge) begin
                    state_d   = ST_START;
                    par_err_d = 1'b0;
                end
            end
            ST_START: begin
                if (half_tick) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        bit_d   = '0;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = (CHECK == PAR_NONE) ? ST_STOP : ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    par_err_d = ((^{shift_q, rx_s_q}) != (CHECK == PAR_ODD));
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    byte_done = 1'b1;
                    frm_err   = ~rx_s_q;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign byte_data = shift_q;
    assign par_err   = par_err_q;
    assign rx_idle   = (state_q == ST_IDLE);

endmodule

// File: rtl/uart_cmd_rx.sv
// UART command receiver: assembles NB bytes into one command word.
// Also handles the valid/ready handshake, error pulses and the inter-byte timeout.
module uart_cmd_rx
    import uart_pkg::*;
#(
    parameter int CMD_WIDTH    = 16,
    parameter int CLK_FREQ     = 50000000,
    parameter int BR           = 115200,
    parameter int CHECK        = PAR_ODD,
    parameter int TIMEOUT_BITS = 22
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [CMD_WIDTH-1:0] cmd_out,
    output logic                 cmd_vld,
    input  logic                 cmd_rdy,
    output logic                 err_parity,
    output logic                 err_frame,
    output logic                 err_ovr
);

    localparam int NB        = CMD_WIDTH / 8;
    localparam int IW        = (NB > 1) ? $clog2(NB) : 1;
    localparam int TO_CYCLES = TIMEOUT_BITS * calcBaudDiv(CLK_FREQ, BR);
    localparam int TW        = $clog2(TO_CYCLES + 1);

    logic [7:0]           byte_data;
    logic                 byte_done, par_err, frm_err, rx_idle;
    logic                 good_byte;
    logic [IW-1:0]        idx_q, idx_d;
    logic [CMD_WIDTH-1:0] asm_q, asm_d;
    logic [CMD_WIDTH-1:0] cmd_q, cmd_d;
    logic                 vld_q, vld_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic [TW-1:0]        tmo_q, tmo_d;

    uart_rx_byte #(
        .CLK_FREQ (CLK_FREQ),
        .BR       (BR),
        .CHECK    (CHECK)
    ) u_rx_byte (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .byte_data (byte_data),
        .byte_done (byte_done),
        .par_err   (par_err),
        .frm_err   (frm_err),
        .rx_idle   (rx_idle)
    );

    assign good_byte = byte_done & ~par_err & ~frm_err;

    // Assembly, command, handshake, error-pulse and timeout registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            asm_q  <= '0;
            cmd_q  <= '0;
            vld_q  <= 1'b0;
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
            tmo_q  <= '0;
        end else begin
            idx_q  <= idx_d;
            asm_q  <= asm_d;
            cmd_q  <= cmd_d;
            vld_q  <= vld_d;
            perr_q <= perr_d;
            ferr_q <= ferr_d;
            ovr_q  <= ovr_d;
            tmo_q  <= tmo_d;
        end
    end

    // A completed command loads only if the output slot is free or is being freed this cycle.
    always_comb begin
        idx_d  = idx_q;
        asm_d  = asm_q;
        cmd_d  = cmd_q;
        vld_d  = vld_q;
        perr_d = 1'b0;
        ferr_d = 1'b0;
        ovr_d  = 1'b0;
        tmo_d  = '0;
        if (vld_q && cmd_rdy) begin
            vld_d = 1'b0;
        end
        if (good_byte) begin
            asm_d = (asm_q << 8) | CMD_WIDTH'(byte_data);
            if (idx_q == IW'(NB - 1)) begin
                idx_d = '0;
                if (!vld_q || cmd_rdy) begin
                    cmd_d = asm_d;
                    vld_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else if (byte_done) begin
            idx_d  = '0;
            perr_d = par_err;
            ferr_d = frm_err;
        end
        if (rx_idle && (idx_q != '0)) begin
            if (tmo_q == TW'(TO_CYCLES - 1)) begin
                idx_d = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    assign cmd_out    = cmd_q;
    assign cmd_vld    = vld_q;
    assign err_parity = perr_q;
    assign err_frame  = ferr_q;
    assign err_ovr    = ovr_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx with a short bit period (200 clocks per bit).
module tb_uart_cmd_rx;

    localparam int BIT = 200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx;
    logic        cmd_rdy;
    logic [15:0] cmd_out;
    logic        cmd_vld;
    logic        err_parity, err_frame, err_ovr;

    int          checks = 0;
    int          errors = 0;
    int          parCnt = 0, frmCnt = 0, ovrCnt = 0, accCnt = 0;
    logic [15:0] lastCmd = '0;
    int          p0, f0, o0, a0;

    always #5 clk = ~clk;

    uart_cmd_rx #(
        .CMD_WIDTH    (16),
        .CLK_FREQ     (23040000),
        .BR           (115200),
        .CHECK        (1),
        .TIMEOUT_BITS (22)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .cmd_out    (cmd_out),
        .cmd_vld    (cmd_vld),
        .cmd_rdy    (cmd_rdy),
        .err_parity (err_parity),
        .err_frame  (err_frame),
        .err_ovr    (err_ovr)
    );

    // Count error pulses and accepted commands away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            parCnt <= parCnt + int'(err_parity);
            frmCnt <= frmCnt + int'(err_frame);
            ovrCnt <= ovrCnt + int'(err_ovr);
            if (cmd_vld && cmd_rdy) begin
                accCnt  <= accCnt + 1;
                lastCmd <= cmd_out;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One frame: start, 8 data bits LSB first, odd parity (optionally flipped), stop bit.
    task automatic applyStimulus(input logic [7:0] d, input bit badPar, input bit stopBit);
        logic p;
        p = ~(^d) ^ badPar;
        rx = 1'b0;
        repeat (BIT) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT) @(posedge clk);
        end
        rx = p;
        repeat (BIT) @(posedge clk);
        rx = stopBit;
        repeat (BIT) @(posedge clk);
        rx = 1'b1;
    endtask

    task automatic settle(input int cycles);
        repeat (cycles) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic snap();
        p0 = parCnt;
        f0 = frmCnt;
        o0 = ovrCnt;
        a0 = accCnt;
    endtask

    initial begin
        rx      = 1'b1;
        cmd_rdy = 1'b0;
        rst_n   = 1'b0;
        settle(5);
        checkOutput("reset cmd_out", 32'(cmd_out), 32'h0);
        checkOutput("reset cmd_vld", 32'(cmd_vld), 32'h0);
        checkOutput("reset errors", 32'({err_parity, err_frame, err_ovr}), 32'h0);
        rst_n = 1'b1;
        settle(5);

        // Two good bytes form one command, consumed immediately.
        cmd_rdy = 1'b1;
        snap();
        applyStimulus(8'hA5, 1'b0, 1'b1);
        applyStimulus(8'h3C, 1'b0, 1'b1);
        settle(20);
        checkOutput("t1 accepted", 32'(accCnt - a0), 32'd1);
        checkOutput("t1 cmd", 32'(lastCmd), 32'hA53C);
        checkOutput("t1 parity", 32'(parCnt - p0), 32'd0);
        checkOutput("t1 frame", 32'(frmCnt - f0), 32'd0);
        checkOutput("t1 ovr", 32'(ovrCnt - o0), 32'd0);
        checkOutput("t1 vld low", 32'(cmd_vld), 32'h0);

        // Parity error discards the byte; the next two form the command.
        cmd_rdy = 1'b0;
        snap();
        applyStimulus(8'h12, 1'b1, 1'b1);
        applyStimulus(8'h34, 1'b0, 1'b1);
        applyStimulus(8'h56, 1'b0, 1'b1);
        settle(20);
        checkOutput("t2 parity", 32'(parCnt - p0), 32'd1);
        checkOutput("t2 frame", 32'(frmCnt - f0), 32'd0);
        checkOutput("t2 vld", 32'(cmd_vld), 32'h1);
        checkOutput("t2 cmd", 32'(cmd_out), 32'h3456);
        cmd_rdy = 1'b1;
        settle(3);
        checkOutput("t2 vld cleared", 32'(cmd_vld), 32'h0);
        checkOutput("t2 accepted cmd", 32'(lastCmd), 32'h3456);

        // Framing error on the second byte drops the partial command.
        cmd_rdy = 1'b0;
        snap();
        applyStimulus(8'h11, 1'b0, 1'b1);
        applyStimulus(8'h22, 1'b0, 1'b0);
        settle(2 * BIT);
        checkOutput("t3 frame", 32'(frmCnt - f0), 32'd1);
        checkOutput("t3 vld after frame", 32'(cmd_vld), 32'h0);
        applyStimulus(8'hBE, 1'b0, 1'b1);
        applyStimulus(8'hEF, 1'b0, 1'b1);
        settle(20);
        checkOutput("t3 cmd", 32'(cmd_out), 32'hBEEF);
        checkOutput("t3 vld", 32'(cmd_vld), 32'h1);
        checkOutput("t3 parity", 32'(parCnt - p0), 32'd0);
        cmd_rdy = 1'b1;
        settle(3);
        checkOutput("t3 vld cleared", 32'(cmd_vld), 32'h0);

        // Second command while the first is still pending is dropped.
        cmd_rdy = 1'b0;
        snap();
        applyStimulus(8'h11, 1'b0, 1'b1);
        applyStimulus(8'h11, 1'b0, 1'b1);
        settle(20);
        checkOutput("t4 first cmd", 32'(cmd_out), 32'h1111);
        applyStimulus(8'h22, 1'b0, 1'b1);
        applyStimulus(8'h22, 1'b0, 1'b1);
        settle(20);
        checkOutput("t4 cmd kept", 32'(cmd_out), 32'h1111);
        checkOutput("t4 ovr", 32'(ovrCnt - o0), 32'd1);
        checkOutput("t4 vld", 32'(cmd_vld), 32'h1);
        cmd_rdy = 1'b1;
        settle(3);
        checkOutput("t4 vld cleared", 32'(cmd_vld), 32'h0);
        checkOutput("t4 accepted", 32'(accCnt - a0), 32'd1);
        checkOutput("t4 accepted cmd", 32'(lastCmd), 32'h1111);

        // Low glitch shorter than half a bit on an idle line.
        snap();
        rx = 1'b0;
        repeat (80) @(posedge clk);
        rx = 1'b1;
        settle(12 * BIT);
        checkOutput("t5 errors", 32'((parCnt - p0) + (frmCnt - f0) + (ovrCnt - o0)), 32'd0);
        checkOutput("t5 vld", 32'(cmd_vld), 32'h0);

        // Long idle after one byte discards it.
        snap();
        applyStimulus(8'h77, 1'b0, 1'b1);
        repeat (23 * BIT) @(posedge clk);
        applyStimulus(8'h88, 1'b0, 1'b1);
        applyStimulus(8'h99, 1'b0, 1'b1);
        settle(20);
        checkOutput("t6 accepted", 32'(accCnt - a0), 32'd1);
        checkOutput("t6 cmd", 32'(lastCmd), 32'h8899);
        checkOutput("t6 errors", 32'((parCnt - p0) + (frmCnt - f0)), 32'd0);

        // Reset mid-byte with a command pending clears everything at once.
        cmd_rdy = 1'b0;
        applyStimulus(8'hCA, 1'b0, 1'b1);
        applyStimulus(8'hFE, 1'b0, 1'b1);
        settle(20);
        checkOutput("t7 pending cmd", 32'(cmd_out), 32'hCAFE);
        rx = 1'b0;
        repeat (4 * BIT) @(posedge clk);
        rst_n = 1'b0;
        rx    = 1'b1;
        #1;
        checkOutput("t7 reset cmd_out", 32'(cmd_out), 32'h0);
        checkOutput("t7 reset vld", 32'(cmd_vld), 32'h0);
        repeat (3) @(posedge clk);
        rst_n = 1'b1;
        settle(10);
        cmd_rdy = 1'b1;
        snap();
        applyStimulus(8'hDE, 1'b0, 1'b1);
        applyStimulus(8'hAD, 1'b0, 1'b1);
        settle(20);
        checkOutput("t7 accepted", 32'(accCnt - a0), 32'd1);
        checkOutput("t7 cmd", 32'(lastCmd), 32'hDEAD);
        checkOutput("t7 errors", 32'((parCnt - p0) + (frmCnt - f0) + (ovrCnt - o0)), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
